dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arb_rr.sv | 23 ++
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states,
// requester ids and default memory geometry.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DEPTH      = 2 ** ADDR_W_DEF;
  localparam int unsigned MAX_LEN    = 4;

  typedef enum logic {
    IDLE      = 1'b0,
    DMA_BURST = 1'b1
  } state_e;

  typedef enum logic {
    CORE = 1'b0,
    DMA  = 1'b1
  } req_id_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, DMA and memory-side signals around the arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface dmem_arbiter_if;

  logic        c_req_i;
  logic        c_we_i;
  logic [31:0] c_addr_i;
  logic [31:0] c_wdata_i;
  logic        c_gnt_o;
  logic        c_rvalid_o;
  logic [31:0] c_rdata_o;

  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [1:0]  d_len_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        d_done_o;

  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  c_req_i, c_we_i, c_addr_i, c_wdata_i,
    output c_gnt_o, c_rvalid_o, c_rdata_o,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_len_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o, d_done_o,
    output mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output c_req_i, c_we_i, c_addr_i, c_wdata_i,
    input  c_gnt_o, c_rvalid_o, c_rdata_o,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_len_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o, d_done_o,
    input  mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin pick between core and DMA; on a tie the requester
// that did not win last time is chosen. o_gnt is one-hot {dma, core}.
module dmem_arb_rr
  import dmem_arb_pkg::*;
(
  input  logic       i_req_core,
  input  logic       i_req_dma,
  input  req_id_e    i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    if (i_req_core && i_req_dma) begin
      o_gnt = (i_last == DMA) ? 2'b01 : 2'b10;
    end else if (i_req_core) begin
      o_gnt = 2'b01;
    end else if (i_req_dma) begin
      o_gnt = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a single-ported data memory between single-beat core accesses
// and multi-beat DMA bursts; read data returns one cycle after the grant.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned MAX_LEN = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  dmem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(MAX_LEN);

  state_e              r_state, w_state_nxt;
  req_id_e             r_last, w_last_nxt;
  logic [ADDR_W-1:0]   r_base;
  logic                r_base_oob;
  logic                r_we;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_beat, w_beat_nxt;
  logic                r_c_rvalid, r_d_rvalid;
  logic [31:0]         r_c_rdata, r_d_rdata;

  logic [1:0]          w_rr_gnt;
  logic                w_c_gnt, w_d_gnt, w_done, w_latch;
  logic                w_we, w_oob;
  logic [31:0]         w_addr, w_wdata;
  logic [ADDR_W-1:0]   w_beat_addr;
  logic [31:0]         w_rd_data;

  function automatic logic addr_oob(input logic [31:0] a);
    return |a[31:ADDR_W];
  endfunction

  dmem_arb_rr u_rr (
    .i_req_core (bus.c_req_i),
    .i_req_dma  (bus.d_req_i),
    .i_last     (r_last),
    .o_gnt      (w_rr_gnt)
  );

  assign w_beat_addr = r_base + ADDR_W'(r_beat);

  // Everything is gated by rst_ni so outputs read zero while reset is held,
  // even though the grant path is combinational from the request inputs.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_beat_nxt  = r_beat;
    w_c_gnt     = 1'b0;
    w_d_gnt     = 1'b0;
    w_done      = 1'b0;
    w_latch     = 1'b0;
    w_we        = 1'b0;
    w_oob       = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    if (rst_ni) begin
      unique case (r_state)
        IDLE: begin
          if (w_rr_gnt[0]) begin
            w_c_gnt    = 1'b1;
            w_we       = bus.c_we_i;
            w_addr     = bus.c_addr_i;
            w_wdata    = bus.c_wdata_i;
            w_oob      = addr_oob(bus.c_addr_i);
            w_last_nxt = CORE;
          end else if (w_rr_gnt[1]) begin
            w_d_gnt    = 1'b1;
            w_latch    = 1'b1;
            w_we       = bus.d_we_i;
            w_addr     = bus.d_addr_i;
            w_wdata    = bus.d_wdata_i;
            w_oob      = addr_oob(bus.d_addr_i);
            w_last_nxt = DMA;
            if (bus.d_len_i[CNT_W-1:0] == '0) begin
              w_done = 1'b1;
            end else begin
              w_state_nxt = DMA_BURST;
              w_beat_nxt  = CNT_W'(1);
            end
          end
        end
        DMA_BURST: begin
          if (!bus.d_req_i) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
            w_beat_nxt  = '0;
          end else begin
            w_d_gnt = 1'b1;
            w_we    = r_we;
            w_addr  = {{(32-ADDR_W){1'b0}}, w_beat_addr};
            w_wdata = bus.d_wdata_i;
            w_oob   = r_base_oob;
            if (r_beat == r_len) begin
              w_done      = 1'b1;
              w_state_nxt = IDLE;
              w_beat_nxt  = '0;
            end else begin
              w_beat_nxt = r_beat + CNT_W'(1);
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_rd_data = w_oob ? '0 : bus.mem_rdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_last     <= DMA;
      r_beat     <= '0;
      r_base     <= '0;
      r_base_oob <= 1'b0;
      r_we       <= 1'b0;
      r_len      <= '0;
      r_c_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_c_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_beat     <= w_beat_nxt;
      if (w_latch) begin
        r_base     <= bus.d_addr_i[ADDR_W-1:0];
        r_base_oob <= addr_oob(bus.d_addr_i);
        r_we       <= bus.d_we_i;
        r_len      <= bus.d_len_i[CNT_W-1:0];
      end
      r_c_rvalid <= w_c_gnt && !w_we;
      r_d_rvalid <= w_d_gnt && !w_we;
      if (w_c_gnt && !w_we) r_c_rdata <= w_rd_data;
      if (w_d_gnt && !w_we) r_d_rdata <= w_rd_data;
    end
  end

  assign bus.c_gnt_o     = w_c_gnt;
  assign bus.c_rvalid_o  = r_c_rvalid;
  assign bus.c_rdata_o   = r_c_rdata;
  assign bus.d_gnt_o     = w_d_gnt;
  assign bus.d_rvalid_o  = r_d_rvalid;
  assign bus.d_rdata_o   = r_d_rdata;
  assign bus.d_done_o    = w_done;
  assign bus.mem_we_o    = w_we && !w_oob;
  assign bus.mem_addr_o  = w_addr;
  assign bus.mem_wdata_o = w_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64-word memory model whose
// unwritten words read back as 0xCAFE0000 | index.
module tb_dmem_arbiter;

  logic clk_i = 1'b0;
  logic rst_ni;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.ADDR_W(6), .MAX_LEN(4)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  bit   [63:0] wr_valid;
  logic [31:0] wr_data [64];
  logic [5:0]  m_idx;

  assign m_idx = bus.mem_addr_o[5:0];
  assign bus.mem_rdata_i = wr_valid[m_idx] ? wr_data[m_idx] : {16'hCAFE, 10'd0, m_idx};

  always @(posedge clk_i) begin
    if (bus.mem_we_o) begin
      wr_valid[m_idx] <= 1'b1;
      wr_data[m_idx]  <= bus.mem_wdata_o;
    end
  end

  function automatic logic [31:0] mem_word(input int unsigned i);
    logic [5:0] idx;
    idx = 6'(i);
    return wr_valid[idx] ? wr_data[idx] : {16'hCAFE, 10'd0, idx};
  endfunction

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.c_req_i   = 1'b0;
    bus.c_we_i    = 1'b0;
    bus.c_addr_i  = '0;
    bus.c_wdata_i = '0;
    bus.d_req_i   = 1'b0;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = '0;
    bus.d_wdata_i = '0;
    bus.d_len_i   = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    automatic int unsigned exp_addr[4] = '{62, 63, 0, 1};
    clear_inputs();
    rst_ni = 1'b0;
    #1;
    chk("rst_c_gnt",  32'(bus.c_gnt_o), 0);
    chk("rst_d_gnt",  32'(bus.d_gnt_o), 0);
    chk("rst_we",     32'(bus.mem_we_o), 0);
    chk("rst_addr",   bus.mem_addr_o, 0);
    chk("rst_done",   32'(bus.d_done_o), 0);
    chk("rst_crv",    32'(bus.c_rvalid_o), 0);
    chk("rst_crdata", bus.c_rdata_o, 0);
    chk("rst_drdata", bus.d_rdata_o, 0);
    @(negedge clk_i) rst_ni = 1'b1;

    // Core read at 5: grant same cycle, data one cycle later
    @(negedge clk_i);
    bus.c_req_i = 1'b1; bus.c_addr_i = 32'd5;
    #1;
    chk("rd5_gnt",  32'(bus.c_gnt_o), 1);
    chk("rd5_addr", bus.mem_addr_o, 5);
    chk("rd5_we",   32'(bus.mem_we_o), 0);
    @(negedge clk_i);
    clear_inputs();
    #1;
    chk("rd5_rv",    32'(bus.c_rvalid_o), 1);
    chk("rd5_data",  bus.c_rdata_o, 32'hCAFE0005);
    chk("idle_gnt",  32'(bus.c_gnt_o), 0);
    chk("idle_addr", bus.mem_addr_o, 0);
    chk("idle_wd",   bus.mem_wdata_o, 0);
    @(negedge clk_i);
    #1;
    chk("rd5_rv_off", 32'(bus.c_rvalid_o), 0);

    // Ties from a fresh reset: core, then DMA, then core again
    @(negedge clk_i) rst_ni = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    bus.c_req_i = 1'b1; bus.c_addr_i = 32'd1;
    bus.d_req_i = 1'b1; bus.d_addr_i = 32'd2; bus.d_len_i = 2'd0;
    #1;
    chk("tie1_c", 32'(bus.c_gnt_o), 1);
    chk("tie1_d", 32'(bus.d_gnt_o), 0);
    @(negedge clk_i);
    #1;
    chk("tie2_c",    32'(bus.c_gnt_o), 0);
    chk("tie2_d",    32'(bus.d_gnt_o), 1);
    chk("tie2_done", 32'(bus.d_done_o), 1);
    chk("tie2_addr", bus.mem_addr_o, 2);
    chk("tie2_crd",  bus.c_rdata_o, 32'hCAFE0001);
    @(negedge clk_i);
    #1;
    chk("tie3_c",   32'(bus.c_gnt_o), 1);
    chk("tie3_d",   32'(bus.d_gnt_o), 0);
    chk("tie3_drv", 32'(bus.d_rvalid_o), 1);
    chk("tie3_drd", bus.d_rdata_o, 32'hCAFE0002);
    @(negedge clk_i);
    clear_inputs();
    #1;
    chk("tie4_drv", 32'(bus.d_rvalid_o), 0);
    chk("tie4_crv", 32'(bus.c_rvalid_o), 1);

    // DMA write burst wrapping past the top; core waits then goes next
    @(negedge clk_i);
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 32'd62; bus.d_len_i = 2'd3;
    bus.c_req_i = 1'b1; bus.c_we_i = 1'b1; bus.c_addr_i = 32'd10; bus.c_wdata_i = 32'hC0C00010;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk_i);
      bus.d_wdata_i = 32'hD0000000 + 32'(k);
      #1;
      chk($sformatf("bw%0d_dgnt", k), 32'(bus.d_gnt_o), 1);
      chk($sformatf("bw%0d_cgnt", k), 32'(bus.c_gnt_o), 0);
      chk($sformatf("bw%0d_we",   k), 32'(bus.mem_we_o), 1);
      chk($sformatf("bw%0d_addr", k), bus.mem_addr_o, exp_addr[k]);
      chk($sformatf("bw%0d_done", k), 32'(bus.d_done_o), (k == 3) ? 1 : 0);
      chk($sformatf("bw%0d_drv",  k), 32'(bus.d_rvalid_o), 0);
    end
    @(negedge clk_i);
    bus.d_req_i = 1'b0;
    #1;
    chk("bw_after_cgnt", 32'(bus.c_gnt_o), 1);
    chk("bw_after_addr", bus.mem_addr_o, 10);
    chk("bw_after_done", 32'(bus.d_done_o), 0);
    @(negedge clk_i);
    clear_inputs();
    #1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("bw_mem%0d", exp_addr[k]), mem_word(exp_addr[k]), 32'hD0000000 + 32'(k));
    chk("bw_mem10", mem_word(10), 32'hC0C00010);

    // DMA burst aborted after two beats
    @(negedge clk_i);
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 32'd20; bus.d_len_i = 2'd3;
    bus.c_req_i = 1'b1; bus.c_we_i = 1'b1; bus.c_addr_i = 32'd30; bus.c_wdata_i = 32'hC0C00030;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge clk_i);
      bus.d_wdata_i = 32'hE0000000 + 32'(k);
      #1;
      chk($sformatf("ab%0d_dgnt", k), 32'(bus.d_gnt_o), 1);
      chk($sformatf("ab%0d_addr", k), bus.mem_addr_o, 20 + k);
    end
    @(negedge clk_i);
    bus.d_req_i = 1'b0;
    #1;
    chk("ab_stop_dgnt", 32'(bus.d_gnt_o), 0);
    chk("ab_stop_we",   32'(bus.mem_we_o), 0);
    chk("ab_stop_done", 32'(bus.d_done_o), 1);
    chk("ab_stop_cgnt", 32'(bus.c_gnt_o), 0);
    chk("ab_stop_addr", bus.mem_addr_o, 0);
    @(negedge clk_i);
    #1;
    chk("ab_core_gnt",  32'(bus.c_gnt_o), 1);
    chk("ab_core_addr", bus.mem_addr_o, 30);
    @(negedge clk_i);
    clear_inputs();
    #1;
    chk("ab_mem21", mem_word(21), 32'hE0000001);
    chk("ab_mem22", mem_word(22), 32'hCAFE0016);
    chk("ab_mem30", mem_word(30), 32'hC0C00030);

    // Reset during beat 2 of a DMA read burst
    @(negedge clk_i);
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'd40; bus.d_len_i = 2'd3;
    #1;
    chk("rb0_addr", bus.mem_addr_o, 40);
    @(negedge clk_i);
    #1;
    chk("rb1_addr", bus.mem_addr_o, 41);
    chk("rb1_drd",  bus.d_rdata_o, 32'hCAFE0028);
    @(negedge clk_i);
    #1;
    chk("rb2_dgnt", 32'(bus.d_gnt_o), 1);
    chk("rb2_addr", bus.mem_addr_o, 42);
    rst_ni = 1'b0;
    #1;
    chk("rbr_dgnt", 32'(bus.d_gnt_o), 0);
    chk("rbr_addr", bus.mem_addr_o, 0);
    chk("rbr_drv",  32'(bus.d_rvalid_o), 0);
    chk("rbr_done", 32'(bus.d_done_o), 0);
    chk("rbr_drd",  bus.d_rdata_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    bus.d_req_i = 1'b0;
    #1;
    chk("rbx_done", 32'(bus.d_done_o), 0);
    chk("rbx_drv",  32'(bus.d_rvalid_o), 0);
    @(negedge clk_i);
    #1;
    chk("rbx2_drv", 32'(bus.d_rvalid_o), 0);
    chk("rbx2_done", 32'(bus.d_done_o), 0);

    // Out-of-range core address 0x40
    @(negedge clk_i);
    bus.c_req_i = 1'b1; bus.c_we_i = 1'b1; bus.c_addr_i = 32'h40; bus.c_wdata_i = 32'h12345678;
    #1;
    chk("oob_w_gnt", 32'(bus.c_gnt_o), 1);
    chk("oob_w_we",  32'(bus.mem_we_o), 0);
    @(negedge clk_i);
    bus.c_we_i = 1'b0;
    #1;
    chk("oob_r_gnt", 32'(bus.c_gnt_o), 1);
    chk("oob_w_rv",  32'(bus.c_rvalid_o), 0);
    @(negedge clk_i);
    clear_inputs();
    #1;
    chk("oob_r_rv",   32'(bus.c_rvalid_o), 1);
    chk("oob_r_data", bus.c_rdata_o, 0);
    chk("oob_mem0",   mem_word(0), 32'hD0000002);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
